// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG arbiter and other LFSR consumers.
package rng_pkg;

  // Arbiter FSM states: warm-up (discarding words) or serving requesters.
  typedef enum logic {
    WARM  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Default 16-bit feedback tap mask and reset seed.
  localparam logic [15:0] DEF_TAPS = 16'b1011010000000000;
  localparam logic [15:0] DEF_SEED = 16'hcafe;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_advance_n.sv
// Combinational N-step advance of an XNOR-feedback Fibonacci LFSR.
// All-ones is the lockup state; callers must keep it out of the register.
module lfsr_advance_n
  import rng_pkg::*;
#(
  parameter int              LENGTH = 16,
  parameter int              N      = 8,
  parameter logic [LENGTH-1:0] TAPS = DEF_TAPS
) (
  input  logic [LENGTH-1:0] s,
  output logic [LENGTH-1:0] s_next
);

  // stage[k] is the state after k single steps.
  logic [LENGTH-1:0] stage [0:N];

  assign stage[0] = s;

  // Unrolled chain of single steps: shift left, XNOR of tapped bits enters at bit 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_step
    assign stage[gi+1] = {stage[gi][LENGTH-2:0], ~^(stage[gi] & TAPS)};
  end

  assign s_next = stage[N];

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among NREQ sampling units.
// Each grant delivers the top N bits of the pre-advance state, then the LFSR
// advances N steps. An optional warm-up discards WARMUP words after reset or reseed.
module rng_arbiter
  import rng_pkg::*;
#(
  parameter int                NREQ   = 4,
  parameter int                LENGTH = 16,
  parameter int                N      = 8,
  parameter logic [LENGTH-1:0] TAPS   = DEF_TAPS,
  parameter logic [LENGTH-1:0] SEED   = DEF_SEED,
  parameter int                WARMUP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              seed_load,
  input  logic [LENGTH-1:0] seed_in,
  output logic [NREQ-1:0]   gnt,
  output logic [N-1:0]      rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int     PW        = clog2(NREQ);
  localparam int     WCW       = clog2(WARMUP + 2);
  localparam state_t RST_STATE = (WARMUP > 0) ? WARM : SERVE;

  state_t            state_reg;
  logic [LENGTH-1:0] lfsr_reg;
  logic [LENGTH-1:0] lfsr_adv;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     ptr_next;
  logic [WCW-1:0]    warm_cnt_reg;

  logic              found;
  logic [PW-1:0]     win;
  logic [NREQ-1:0]   win_onehot;
  logic [PW:0]       pick_sum;
  logic [PW-1:0]     pick_idx;

  lfsr_advance_n #(
    .LENGTH (LENGTH),
    .N      (N),
    .TAPS   (TAPS)
  ) u_adv (
    .s      (lfsr_reg),
    .s_next (lfsr_adv)
  );

  // Round-robin pick: scan upward from ptr, wrapping by compare so NREQ need not be a power of two.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    pick_sum = '0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      pick_sum = {1'b0, ptr_reg} + (PW+1)'(k);
      if (pick_sum >= (PW+1)'(NREQ)) begin
        pick_sum = pick_sum - (PW+1)'(NREQ);
      end
      pick_idx = pick_sum[PW-1:0];
      if (!found && req[pick_idx]) begin
        found = 1'b1;
        win   = pick_idx;
      end
    end
  end

  assign win_onehot = NREQ'(1) << win;
  assign ptr_next   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);

  // FSM, LFSR state and registered grant/data; reseed overrides everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= RST_STATE;
      lfsr_reg     <= SEED;
      ptr_reg      <= '0;
      warm_cnt_reg <= WCW'(WARMUP);
      gnt          <= '0;
      rdata        <= '0;
    end else if (seed_load) begin
      // An all-ones seed would lock the XNOR LFSR, so fall back to SEED.
      lfsr_reg     <= (&seed_in) ? SEED : seed_in;
      gnt          <= '0;
      warm_cnt_reg <= WCW'(WARMUP);
      state_reg    <= RST_STATE;
    end else begin
      case (state_reg)
        WARM: begin
          lfsr_reg     <= lfsr_adv;
          warm_cnt_reg <= warm_cnt_reg - WCW'(1);
          gnt          <= '0;
          if (warm_cnt_reg == WCW'(1)) begin
            state_reg <= SERVE;
          end
        end
        SERVE: begin
          if (found) begin
            gnt      <= win_onehot;
            rdata    <= lfsr_reg[LENGTH-1 -: N];
            lfsr_reg <= lfsr_adv;
            ptr_reg  <= ptr_next;
          end else begin
            gnt <= '0;
          end
        end
        default: begin
          state_reg <= RST_STATE;
        end
      endcase
    end
  end

  assign rvalid = |gnt;
  assign busy   = (state_reg == WARM);

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: a WARMUP=0 instance checked against a
// scoreboard-fed reference model, plus a WARMUP=4 instance for warm-up timing.
module tb_rng_arbiter;

  localparam logic [15:0] TAPS = 16'b1011010000000000;
  localparam logic [15:0] SEED = 16'hcafe;

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;

  logic [3:0]  gnt0, gnt4;
  logic [7:0]  rdata0, rdata4;
  logic        rvalid0, rvalid4, busy0, busy4;

  int          n_assert = 0;
  int          n_fail = 0;
  exp_t        sb[$];

  logic [15:0] m_s = SEED;
  int          m_ptr = 0;
  logic [7:0]  m_rdata = '0;
  logic [7:0]  held;
  logic [15:0] warm_s;

  always #5 clk = ~clk;

  rng_arbiter #(.NREQ(4), .LENGTH(16), .N(8), .TAPS(TAPS), .SEED(SEED), .WARMUP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .gnt(gnt0), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
  );

  rng_arbiter #(.NREQ(4), .LENGTH(16), .N(8), .TAPS(TAPS), .SEED(SEED), .WARMUP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .gnt(gnt4), .rdata(rdata4), .rvalid(rvalid4), .busy(busy4)
  );

  function automatic logic [15:0] adv8(input logic [15:0] s);
    logic        fb;
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      fb = ~^(t & TAPS);
      t  = {t[14:0], fb};
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: model predicts dut0 output from current inputs, pushes it, then pops and compares.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t got;
    int   w;
    int   idx;
    e.gnt   = '0;
    e.rdata = m_rdata;
    w       = -1;
    if (!rst_n) begin
      m_s     = SEED;
      m_ptr   = 0;
      e.rdata = '0;
    end else if (seed_load) begin
      m_s = (seed_in == 16'hffff) ? SEED : seed_in;
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (w < 0 && req[idx[1:0]]) w = idx;
      end
      if (w >= 0) begin
        e.gnt   = 4'(1 << w);
        e.rdata = m_s[15:8];
        m_s     = adv8(m_s);
        m_ptr   = (w + 1) % 4;
      end
    end
    m_rdata = e.rdata;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ":gnt"}, 32'(gnt0), 32'(got.gnt));
    check({tag, ":rdata"}, 32'(rdata0), 32'(got.rdata));
    check({tag, ":rvalid"}, 32'(rvalid0), 32'(|got.gnt));
    $display("txn %s req=%b gnt=%b rdata=%h busy4=%b gnt4=%b", tag, req, gnt0, rdata0, busy4, gnt4);
  endtask

  initial begin
    logic [3:0] seq2 [0:4];
    logic [3:0] seq3 [0:2];
    seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq3 = '{4'b0100, 4'b0001, 4'b0100};

    // Reset state
    cycle("rst0");
    cycle("rst1");
    check("rst:busy0", 32'(busy0), 32'd0);
    check("rst:busy4", 32'(busy4), 32'd1);
    check("rst:gnt4", 32'(gnt4), 32'd0);

    // 1: sole requester granted every cycle
    rst_n = 1'b1;
    req   = 4'b0001;
    cycle("t1a");
    check("t1a:ca", 32'(rdata0), 32'h00ca);
    check("t1a:g", 32'(gnt0), 32'b0001);
    cycle("t1b");
    check("t1b:fe", 32'(rdata0), 32'h00fe);
    cycle("t1c");
    check("t1c:g", 32'(gnt0), 32'b0001);

    // 2: all requesting from reset -> rotation
    rst_n = 1'b0;
    cycle("t2rst");
    rst_n = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle("t2");
      check("t2:seq", 32'(gnt0), 32'(seq2[i]));
    end

    // 3: sparse requests with ptr=1, then idle gap
    req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      cycle("t3");
      check("t3:seq", 32'(gnt0), 32'(seq3[i]));
    end
    held = rdata0;
    req  = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      cycle("t3idle");
      check("t3idle:hold", 32'(rdata0), 32'(held));
    end
    req = 4'b0101;
    cycle("t3resume");
    cycle("t3resume");

    // 4: warm-up instance from reset release
    rst_n = 1'b0;
    req   = 4'b1111;
    cycle("t4rst");
    check("t4rst:busy4", 32'(busy4), 32'd1);
    check("t4rst:gnt4", 32'(gnt4), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("t4warm");
      check("t4warm:busy4", 32'(busy4), 32'd1);
      check("t4warm:gnt4", 32'(gnt4), 32'd0);
    end
    cycle("t4last");
    check("t4last:busy4", 32'(busy4), 32'd0);
    check("t4last:gnt4", 32'(gnt4), 32'd0);
    cycle("t4first");
    warm_s = adv8(adv8(adv8(adv8(SEED))));
    check("t4first:gnt4", 32'(gnt4), 32'b0001);
    check("t4first:rdata4", 32'(rdata4), 32'(warm_s[15:8]));
    check("t4first:rvalid4", 32'(rvalid4), 32'd1);

    // 5: reseed mid-stream
    seed_load = 1'b1;
    seed_in   = 16'hffff;
    cycle("t5load");
    check("t5load:g", 32'(gnt0), 32'd0);
    seed_load = 1'b0;
    cycle("t5next");
    check("t5next:ca", 32'(rdata0), 32'h00ca);
    cycle("t5more");
    seed_load = 1'b1;
    seed_in   = 16'h5555;
    cycle("t5l1");
    seed_in   = 16'h1234;
    cycle("t5l2");
    check("t5l2:g", 32'(gnt0), 32'd0);
    seed_load = 1'b0;
    cycle("t5next2");
    check("t5next2:12", 32'(rdata0), 32'h0012);

    // 6: reset mid-grant at ptr=2
    rst_n = 1'b0;
    cycle("t6pre");
    rst_n = 1'b1;
    cycle("t6a");
    cycle("t6b");
    rst_n = 1'b0;
    cycle("t6rst");
    check("t6rst:g", 32'(gnt0), 32'd0);
    rst_n = 1'b1;
    cycle("t6after");
    check("t6after:g", 32'(gnt0), 32'b0001);
    check("t6after:ca", 32'(rdata0), 32'h00ca);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_arbiter.md
Name: rng_arbiter

Overview:
- Shares one N-bit-per-grant LFSR random source among NREQ RBM sampling units (neuron/sigmoid comparators) so they need not each own an LFSR.
- Round-robin arbitration, one N-bit word per grant, with an optional warm-up that discards early words.
- Runtime reseed port for experiment repeatability.
- Sits between the RBM update pipeline and the random source. It owns the LFSR state register and sequences its advancement.

Parameters:
- NREQ, 4, number of requesters (>=2).
- LENGTH, 16, LFSR length.
- N, 8, bits delivered per grant (1 <= N <= LENGTH).
- TAPS, 16'b1011010000000000, feedback tap mask (LENGTH bits).
- SEED, 16'hcafe, reset seed (LENGTH bits, must not be all-ones).
- WARMUP, 4, warm-up cycles after reset/reseed (0 = none).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  NREQ  per-requester level request; each cycle high = wants one word.
- seed_load  in  1  load seed_in into LFSR this cycle.
- seed_in  in  LENGTH  new seed.
- gnt  out  NREQ  registered one-hot grant; at most one bit high.
- rdata  out  N  registered random word, valid with gnt.
- rvalid  out  1  equals |gnt.
- busy  out  1  high while in WARM state.

Behaviour:
- LFSR single step:
  - fb = ~^(s & TAPS)
  - s <= {s[LENGTH-2:0], fb}
  - An "advance" means N single steps in one cycle, computed combinationally. XNOR feedback, so the all-ones state is the lockup state.
- Word output: rdata <= s[LENGTH-1 -: N], taken from the pre-advance state. The state advances on every grant and on every WARM cycle. It does not advance otherwise.
- FSM has two states:
  - WARM: warm-up in progress.
  - SERVE: arbitration active.
- Reset (rst_n low at a clock edge):
  - Outputs: gnt=0, rdata=0, rvalid=0.
  - Internal: s=SEED, ptr=0, warm_cnt=WARMUP.
  - State = WARM if WARMUP>0, else SERVE. busy = (state==WARM).
- WARM:
  - Each cycle: advance, warm_cnt--, gnt=0.
  - When warm_cnt reaches 1 the next state is SERVE.
  - Result: exactly WARMUP advance cycles, with req ignored.
- SERVE arbitration:
  - Candidates are req bits at or above ptr, wrapping to 0.
  - The lowest-index candidate i wins: gnt <= onehot(i), rdata <= current top N bits, advance, ptr <= (i+1) mod NREQ.
  - With no req: gnt <= 0, rdata holds, no advance, ptr holds.
- Latency:
  - req sampled at edge k gives gnt/rdata visible after edge k (1 cycle).
  - A requester holding req continuously receives one word per turn.
  - A sole requester is granted every cycle.
- seed_load (priority over everything except reset), in either state:
  - Next state: s <= (seed_in all-ones ? SEED : seed_in), gnt <= 0, warm_cnt <= WARMUP, ptr unchanged.
  - State <= WARM if WARMUP>0, else SERVE.
  - No advance in the load cycle.
- seed_load asserted on consecutive cycles: each cycle reloads and restarts warm-up.
- Reset mid-grant: in-flight grant dropped; gnt=0 next cycle; no residual state.
- NREQ not a power of two: ptr wrap uses an explicit compare, not a bit mask.

Decomposition:
- Package rng_pkg:
  - state enum {WARM, SERVE}.
  - Default TAPS and SEED constants.
  - Function clog2 for ptr width.
- Sub-module lfsr_advance_n (combinational): params LENGTH, N, TAPS; in s; out s_next (N single steps). It is reused by other RNG consumers.
- Round-robin pick stays inline.

Test Plan:
1. WARMUP=0, N=8, default SEED; after reset release, hold req=4'b0001 → gnt=0001 every cycle; rdata=8'hca on first grant, 8'hfe on second.
2. WARMUP=0, req=4'b1111 held → gnt sequence 0001, 0010, 0100, 1000, 0001; rvalid=1 every cycle; each rdata matches the software model advancing 8 steps per grant.
3. WARMUP=0, req=4'b0101 after a grant to requester 0 (ptr=1) → gnt 0100 then 0001 then 0100; req=0 for 3 cycles → gnt=0, rdata held, LFSR not advanced (next word continues the sequence).
4. WARMUP=4, req=4'b1111 from reset release → busy=1 and gnt=0 for 4 cycles; first gnt=0001 on cycle 5; its rdata equals the top 8 bits of SEED advanced 32 steps.
5. WARMUP=0, mid-stream seed_load=1, seed_in=16'hffff → gnt=0 that cycle; state forced to 16'hcafe; next grant rdata=8'hca. Repeat with seed_in=16'h1234 → next rdata=8'h12.
6. rst_n low for 1 cycle during req=4'b1111 at ptr=2 → gnt=0 after that edge; next grant is 0001, showing ptr reset to 0; rdata=8'hca (WARMUP=0).
